// File: rtl/round_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : round_timer_ctrl
//  Description : Per-round countdown sequencer. Owns the seconds counter shown
//                on the two-digit timer display, handles start/restart/pause,
//                pulses expiry to the game FSM and generates the display
//                multiplex clock.
//                Optional bonus-time feature: define ROUND_TIMER_BONUS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module round_timer_ctrl #(
  parameter int CLK_HZ     = 100000000,
  parameter int ROUND_SECS = 30,
  parameter int DISP_HZ    = 500,
  parameter int BONUS_SECS = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pause,
  input  logic       correct,
  output logic [5:0] time_remaining,
  output logic       running,
  output logic       expired,
  output logic       display_clk
);

  localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int DIV   = CLK_HZ / (2 * DISP_HZ);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PRE_W-1:0] c_PRE_LAST = PRE_W'(CLK_HZ - 1);
  localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [5:0]       c_ROUND    = 6'(ROUND_SECS);

  // Reject illegal configurations at elaboration time.
  generate
    if (ROUND_SECS < 1 || ROUND_SECS > 59) begin : g_bad_round
      $error("round_timer_ctrl: ROUND_SECS must be in 1..59");
    end
    if (DISP_HZ < 1 || DIV < 1 || (CLK_HZ % (2 * DISP_HZ)) != 0) begin : g_bad_disp
      $error("round_timer_ctrl: CLK_HZ/(2*DISP_HZ) must be an integer >= 1");
    end
    if (BONUS_SECS < 0 || BONUS_SECS > 59) begin : g_bad_bonus
      $error("round_timer_ctrl: BONUS_SECS must be in 0..59");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [PRE_W-1:0] r_pre, w_pre_nxt;
  logic [5:0]       r_time, w_time_nxt, w_time_dec, w_time_bon;
  logic             r_expired, w_expired_nxt;
  logic             r_running;
  logic             w_tick;
  logic [DIV_W-1:0] r_div;
  logic             r_disp;

`ifdef ROUND_TIMER_BONUS_EN
  logic [6:0]       w_time_sum;
`else
  logic             w_unused_correct;
  assign w_unused_correct = correct;
`endif

  // Next-state, prescaler and seconds-counter decode; start overrides everything.
  always_comb begin
    w_state_nxt   = r_state;
    w_pre_nxt     = r_pre;
    w_time_nxt    = r_time;
    w_expired_nxt = 1'b0;
    w_tick        = 1'b0;
    w_time_dec    = r_time;
    w_time_bon    = r_time;
`ifdef ROUND_TIMER_BONUS_EN
    w_time_sum    = 7'd0;
`endif
    if (start) begin
      w_time_nxt  = c_ROUND;
      w_pre_nxt   = '0;
      w_state_nxt = pause ? ST_PAUSED : ST_RUN;
    end else if (r_state == ST_RUN || r_state == ST_PAUSED) begin
      // Pause level decides the state; the prescaler only advances while it is low,
      // so leaving PAUSED counts on the same edge and no partial second is lost.
      w_state_nxt = pause ? ST_PAUSED : ST_RUN;
      if (!pause) begin
        if (r_pre == c_PRE_LAST) begin
          w_pre_nxt = '0;
          w_tick    = (r_time != 6'd0);
        end else begin
          w_pre_nxt = r_pre + PRE_W'(1);
        end
      end
      w_time_dec = r_time - {5'd0, w_tick};
`ifdef ROUND_TIMER_BONUS_EN
      w_time_sum = {1'b0, w_time_dec} + 7'(BONUS_SECS);
      if (correct) begin
        w_time_bon = (w_time_sum > 7'd59) ? 6'd59 : w_time_sum[5:0];
      end else begin
        w_time_bon = w_time_dec;
      end
`else
      w_time_bon = w_time_dec;
`endif
      w_time_nxt = w_time_bon;
      if (w_tick && w_time_bon == 6'd0) begin
        w_state_nxt   = ST_EXPIRED;
        w_expired_nxt = 1'b1;
      end
    end
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_pre     <= '0;
      r_time    <= c_ROUND;
      r_expired <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pre     <= w_pre_nxt;
      r_time    <= w_time_nxt;
      r_expired <= w_expired_nxt;
      r_running <= (w_state_nxt == ST_RUN);
    end
  end

  // Free-running display divider, toggles every DIV cycles regardless of state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div  <= '0;
      r_disp <= 1'b0;
    end else if (r_div == c_DIV_LAST) begin
      r_div  <= '0;
      r_disp <= ~r_disp;
    end else begin
      r_div  <= r_div + DIV_W'(1);
    end
  end

  assign time_remaining = r_time;
  assign running        = r_running;
  assign expired        = r_expired;
  assign display_clk    = r_disp;

endmodule
`default_nettype wire

// File: tb/tb_round_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_round_timer_ctrl
//  Description : Self-checking bench for round_timer_ctrl: directed vector
//                table plus randomized traffic against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_round_timer_ctrl;

  localparam int CLK_HZ     = 10;
  localparam int ROUND_SECS = 3;
  localparam int DISP_HZ    = 1;
  localparam int BONUS_SECS = 5;
  localparam int DIV        = CLK_HZ / (2 * DISP_HZ);
`ifdef ROUND_TIMER_BONUS_EN
  localparam bit BONUS_ON = 1'b1;
`else
  localparam bit BONUS_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       correct = 1'b0;
  logic [5:0] time_remaining;
  logic       running;
  logic       expired;
  logic       display_clk;

  round_timer_ctrl #(
    .CLK_HZ    (CLK_HZ),
    .ROUND_SECS(ROUND_SECS),
    .DISP_HZ   (DISP_HZ),
    .BONUS_SECS(BONUS_SECS)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .pause         (pause),
    .correct       (correct),
    .time_remaining(time_remaining),
    .running       (running),
    .expired       (expired),
    .display_clk   (display_clk)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: a round is "active" from start until expiry; every
  // active cycle with pause low advances a sub-second fraction, and CLK_HZ of
  // those make one second.
  int m_t;
  int m_frac;
  bit m_active;
  bit m_run;
  bit m_exp;
  int n_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_t      = ROUND_SECS;
    m_frac   = 0;
    m_active = 1'b0;
    m_run    = 1'b0;
    m_exp    = 1'b0;
  endtask

  task automatic model_edge(input bit st, input bit pz, input bit cr);
    int nt;
    bit sec;
    m_exp = 1'b0;
    if (st) begin
      m_t      = ROUND_SECS;
      m_frac   = 0;
      m_active = 1'b1;
    end else if (m_active) begin
      sec = 1'b0;
      if (!pz) begin
        m_frac++;
        if (m_frac == CLK_HZ) begin
          m_frac = 0;
          sec    = 1'b1;
        end
      end
      nt = m_t - (sec ? 1 : 0);
      if (cr && BONUS_ON) nt = (nt + BONUS_SECS > 59) ? 59 : nt + BONUS_SECS;
      if (sec && nt == 0) begin
        m_active = 1'b0;
        m_exp    = 1'b1;
      end
      m_t = nt;
    end
    m_run = m_active && !pz;
  endtask

  // One clock: drive inputs, take the edge, advance the model, compare.
  task automatic step(input bit st, input bit pz, input bit cr);
    start   = st;
    pause   = pz;
    correct = cr;
    @(posedge clk);
    #1;
    n_cyc++;
    model_edge(st, pz, cr);
    chk("model_time",    32'(time_remaining), 32'(m_t));
    chk("model_running", 32'(running),        32'(m_run));
    chk("model_expired", 32'(expired),        32'(m_exp));
    chk("model_dispclk", 32'(display_clk),    32'((n_cyc / DIV) % 2));
  endtask

  // Assert reset away from the clock edge; outputs must clear at once.
  task automatic do_reset();
    start   = 1'b0;
    pause   = 1'b0;
    correct = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk("rst_time",    32'(time_remaining), 32'(ROUND_SECS));
    chk("rst_running", 32'(running),        32'd0);
    chk("rst_expired", 32'(expired),        32'd0);
    chk("rst_dispclk", 32'(display_clk),    32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_cyc = 0;
  endtask

  typedef struct {
    bit rs;     // apply reset instead of cycles
    int n;      // cycles to hold the inputs (start only on the first)
    bit st;
    bit pz;
    bit cr;
    int t;      // expected outputs after the last cycle
    bit run;
    bit ex;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit rs, input int n, input bit st, input bit pz,
                              input bit cr, input int t, input bit run, input bit ex);
    vec_t v;
    v.rs = rs; v.n = n; v.st = st; v.pz = pz; v.cr = cr;
    v.t = t; v.run = run; v.ex = ex;
    vecs.push_back(v);
  endfunction

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    model_reset();
    n_cyc = 0;
    #2;

    // Idle after reset: pause/correct ignored, display divider running.
    add(1, 0, 0, 0, 0, 3, 0, 0);
    add(0, 20, 0, 1, 1, 3, 0, 0);
    // Full countdown, expiry, ignored inputs in EXPIRED, restart.
    add(0, 1, 1, 0, 0, 3, 1, 0);
    add(0, 9, 0, 0, 0, 3, 1, 0);
    add(0, 1, 0, 0, 0, 2, 1, 0);
    add(0, 10, 0, 0, 0, 1, 1, 0);
    add(0, 9, 0, 0, 0, 1, 1, 0);
    add(0, 1, 0, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 8, 0, 1, 1, 0, 0, 0);
    add(0, 1, 1, 0, 0, 3, 1, 0);
    add(0, 10, 0, 0, 0, 2, 1, 0);
    // Pause for cycles 4..13: first decrement at 20, expiry at 40.
    add(0, 1, 1, 0, 0, 3, 1, 0);
    add(0, 3, 0, 0, 0, 3, 1, 0);
    add(0, 10, 0, 1, 0, 3, 0, 0);
    add(0, 6, 0, 0, 0, 3, 1, 0);
    add(0, 1, 0, 0, 0, 2, 1, 0);
    add(0, 19, 0, 0, 0, 1, 1, 0);
    add(0, 1, 0, 0, 0, 0, 0, 1);
    // Restart at cycle 15: decrements at 25, 35, expiry at 45.
    add(0, 1, 1, 0, 0, 3, 1, 0);
    add(0, 14, 0, 0, 0, 2, 1, 0);
    add(0, 1, 1, 0, 0, 3, 1, 0);
    add(0, 9, 0, 0, 0, 3, 1, 0);
    add(0, 1, 0, 0, 0, 2, 1, 0);
    add(0, 19, 0, 0, 0, 1, 1, 0);
    add(0, 1, 0, 0, 0, 0, 0, 1);
    // Start with pause high, then release.
    add(0, 1, 1, 1, 0, 3, 0, 0);
    add(0, 4, 0, 1, 0, 3, 0, 0);
    add(0, 9, 0, 0, 0, 3, 1, 0);
    add(0, 1, 0, 0, 0, 2, 1, 0);
    // Reset mid-round.
    add(1, 0, 0, 0, 0, 3, 0, 0);
    add(0, 3, 0, 0, 0, 3, 0, 0);
    // Bonus: correct on the final tick, then saturation.
    add(0, 1, 1, 0, 0, 3, 1, 0);
    add(0, 10, 0, 0, 0, 2, 1, 0);
    add(0, 10, 0, 0, 0, 1, 1, 0);
    add(0, 9, 0, 0, 0, 1, 1, 0);
`ifdef ROUND_TIMER_BONUS_EN
    add(0, 1, 0, 0, 1, 5, 1, 0);
    add(0, 11, 0, 0, 1, 59, 1, 0);
    add(0, 1, 1, 0, 1, 3, 1, 0);
`else
    add(0, 1, 0, 0, 1, 0, 0, 1);
    add(0, 11, 0, 0, 1, 0, 0, 0);
    add(0, 1, 1, 0, 1, 3, 1, 0);
`endif

    foreach (vecs[i]) begin
      if (vecs[i].rs) begin
        do_reset();
      end else begin
        for (int k = 0; k < vecs[i].n; k++) begin
          step((k == 0) ? vecs[i].st : 1'b0, vecs[i].pz, vecs[i].cr);
          if (k < vecs[i].n - 1) chk("tbl_expired_mid", 32'(expired), 32'd0);
        end
        chk("tbl_time",    32'(time_remaining), 32'(vecs[i].t));
        chk("tbl_running", 32'(running),        32'(vecs[i].run));
        chk("tbl_expired", 32'(expired),        32'(vecs[i].ex));
      end
    end

    // Randomized traffic against the model.
    begin
      bit pz_lvl;
      pz_lvl = 1'b0;
      for (int c = 0; c < 3000; c++) begin
        if ($urandom_range(0, 499) == 0) begin
          do_reset();
        end else begin
          if ($urandom_range(0, 9) == 0) pz_lvl = ~pz_lvl;
          step($urandom_range(0, 59) == 0, pz_lvl, $urandom_range(0, 7) == 0);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
